// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register: PC, variable-latency fetch, freeze hold, branch squash.
// Define FETCH_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              ld,
    output logic [ADDR_W-1:0] pc_next,
`ifdef FETCH_PERF_CNT_EN
    output logic [INST_W-1:0] instr,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`else
    output logic [INST_W-1:0] instr
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] r_pc_next;
    logic [INST_W-1:0] r_instr;
    logic              r_squash;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_wait_ack;
    logic              w_capture;
    logic              w_release;

    assign w_pc_inc   = r_pc + ADDR_W'(PC_STEP);
    assign w_wait_ack = (r_state == S_WAIT) && mem_ack;
    assign w_capture  = w_wait_ack && !r_squash && !branch_taken;
    assign w_release  = (r_state == S_HOLD) && !freeze && !branch_taken;

    // Gated by rst so request/strobe drop the instant reset asserts, not at the next edge.
    assign mem_req  = rst && (r_state != S_HOLD);
    assign mem_addr = r_pc;
    assign ld       = rst && ((w_capture && !freeze) || w_release);
    assign pc_next  = w_capture ? w_pc_inc  : r_pc_next;
    assign instr    = w_capture ? mem_rdata : r_instr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_target  <= '0;
            r_pc_next <= '0;
            r_instr   <= '0;
            r_squash  <= 1'b0;
        end else if (branch_taken) begin
            if ((r_state == S_WAIT) && !mem_ack) begin
                // Fetch still in flight: remember the target, drop the data when it lands.
                r_target <= branch_addr;
                r_squash <= 1'b1;
            end else begin
                r_pc     <= branch_addr;
                r_squash <= 1'b0;
                r_state  <= S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (mem_ack) begin
                        if (r_squash) begin
                            r_squash <= 1'b0;
                            r_pc     <= r_target;
                            r_state  <= S_REQ;
                        end else begin
                            r_instr   <= mem_rdata;
                            r_pc_next <= w_pc_inc;
                            if (freeze) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_REQ;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        r_pc    <= r_pc_next;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    logic        w_stall;

    assign w_stall      = ((r_state == S_WAIT) && !mem_ack) || (r_state == S_HOLD);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (branch_taken && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, slow ack, freeze, branch squash, reset, wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ld;
    logic [31:0] pc_next;
    logic [31:0] instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .ld           (ld),
        .pc_next      (pc_next),
`ifdef FETCH_PERF_CNT_EN
        .instr        (instr),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`else
        .instr        (instr)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are observed 1 ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_tests++; if (ld !== 1'b0) begin n_fail++; $display("FAIL reset_ld got=%b exp=0", ld); end
        n_tests++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next got=%h exp=0", pc_next); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL release_mem_req got=%b exp=1", mem_req); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL release_mem_addr got=%h exp=0", mem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (mem_addr !== 32'(i * 4) || ld !== 1'b0)
                begin n_fail++; $display("FAIL seq_req%0d addr=%h ld=%b exp addr=%h ld=0", i, mem_addr, ld, i * 4); end
            step();
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            n_tests++; if (ld !== 1'b1 || pc_next !== 32'((i + 1) * 4))
                begin n_fail++; $display("FAIL seq_ld%0d ld=%b pc_next=%h exp ld=1 pc_next=%h", i, ld, pc_next, (i + 1) * 4); end
            n_tests++; if (instr !== 32'hA000_0000 + 32'(i))
                begin n_fail++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr, 32'hA000_0000 + 32'(i)); end
            step();
            mem_ack = 1'b0;
            #1;
        end
    endtask

    task automatic test_delayed_ack();
        int n_ld = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
                begin n_fail++; $display("FAIL slow_hold%0d req=%b addr=%h exp req=1 addr=0", i, mem_req, mem_addr); end
            if (ld === 1'b1) n_ld++;
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        if (ld === 1'b1) n_ld++;
        n_tests++; if (pc_next !== 32'h4 || instr !== 32'h1234_5678)
            begin n_fail++; $display("FAIL slow_data pc_next=%h instr=%h exp 4/12345678", pc_next, instr); end
        step();
        mem_ack = 1'b0;
        #1;
        if (ld === 1'b1) n_ld++;
        n_tests++; if (n_ld != 1) begin n_fail++; $display("FAIL slow_ld_count got=%0d exp=1", n_ld); end
        n_tests++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL slow_next_addr got=%h exp=4", mem_addr); end
    endtask

    task automatic test_freeze();
        do_reset();
        step();
        freeze = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hE3A0_1005;
        #1;
        n_tests++; if (ld !== 1'b0) begin n_fail++; $display("FAIL frz_ack_ld got=%b exp=0", ld); end
        for (int i = 0; i < 4; i++) begin
            step();
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            #1;
            n_tests++; if (ld !== 1'b0 || mem_req !== 1'b0)
                begin n_fail++; $display("FAIL frz_hold%0d ld=%b req=%b exp 0/0", i, ld, mem_req); end
            n_tests++; if (instr !== 32'hE3A0_1005 || pc_next !== 32'h4)
                begin n_fail++; $display("FAIL frz_held%0d instr=%h pc_next=%h exp E3A01005/4", i, instr, pc_next); end
        end
        step();
        freeze = 1'b0;
        #1;
        n_tests++; if (ld !== 1'b1 || instr !== 32'hE3A0_1005 || pc_next !== 32'h4)
            begin n_fail++; $display("FAIL frz_release ld=%b instr=%h pc_next=%h exp 1/E3A01005/4", ld, instr, pc_next); end
        step();
        n_tests++; if (mem_addr !== 32'h4 || mem_req !== 1'b1)
            begin n_fail++; $display("FAIL frz_next_addr addr=%h req=%b exp 4/1", mem_addr, mem_req); end
    endtask

    task automatic test_branch_squash();
        do_reset();
        step();
        branch_taken = 1'b1; branch_addr = 32'h100;
        #1;
        n_tests++; if (ld !== 1'b0) begin n_fail++; $display("FAIL br_wait_ld got=%b exp=0", ld); end
        step();
        branch_taken = 1'b0; branch_addr = 32'h0;
        #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin n_fail++; $display("FAIL br_inflight req=%b addr=%h exp 1/0", mem_req, mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        n_tests++; if (ld !== 1'b0) begin n_fail++; $display("FAIL br_squash_ld got=%b exp=0", ld); end
        step();
        mem_ack = 1'b0;
        #1;
        n_tests++; if (mem_addr !== 32'h100 || ld !== 1'b0)
            begin n_fail++; $display("FAIL br_target addr=%h ld=%b exp 100/0", mem_addr, ld); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h600D_600D;
        #1;
        n_tests++; if (ld !== 1'b1 || pc_next !== 32'h104 || instr !== 32'h600D_600D)
            begin n_fail++; $display("FAIL br_first ld=%b pc_next=%h instr=%h exp 1/104/600D600D", ld, pc_next, instr); end
        step();
        mem_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            mem_ack = 1'b1; mem_rdata = 32'h7700_0000 + 32'(i);
            step();
            mem_ack = 1'b0;
        end
        step();
        #1;
        n_tests++; if (mem_addr !== 32'h8 || mem_req !== 1'b1)
            begin n_fail++; $display("FAIL rst_pre addr=%h req=%b exp 8/1", mem_addr, mem_req); end
        #1;
        rst = 1'b0;
        #1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        n_tests++; if (mem_req !== 1'b0 || ld !== 1'b0 || pc_next !== 32'h0 || instr !== 32'h0)
            begin n_fail++; $display("FAIL rst_mid req=%b ld=%b pc_next=%h instr=%h exp all 0", mem_req, ld, pc_next, instr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (mem_addr !== 32'h0 || ld !== 1'b0 || mem_req !== 1'b1)
            begin n_fail++; $display("FAIL rst_after addr=%h ld=%b req=%b exp 0/0/1", mem_addr, ld, mem_req); end
        mem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        #1;
        n_tests++; if (ld !== 1'b0) begin n_fail++; $display("FAIL wrap_br_ld got=%b exp=0", ld); end
        step();
        branch_taken = 1'b0;
        #1;
        n_tests++; if (mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h exp=FFFFFFFC", mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        n_tests++; if (ld !== 1'b1 || pc_next !== 32'h0)
            begin n_fail++; $display("FAIL wrap_pc_next ld=%b pc_next=%h exp 1/0", ld, pc_next); end
        step();
        mem_ack = 1'b0;
        #1;
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got=%h exp=0", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_freeze();
        test_branch_squash();
        test_reset_mid_wait();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
